// File: rtl/shift_result_stage.sv
// Two-entry result FIFO behind an 8-bit left shifter.
// Flags are derived at push time; the head entry drives the outputs.
module shift_result_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] x,
    input  logic [2:0] amt,
    input  logic [7:0] y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] r,
    output logic       zf,
    output logic       nf,
    output logic       cf,
    output logic       vf,
    output logic [1:0] count
);

    logic [11:0] r_mem [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_lost;
    logic [7:0]  w_last;
    logic        w_zf;
    logic        w_nf;
    logic        w_cf;
    logic        w_vf;

    // Bits x[7:8-amt] leave the register; the last one out is x[8-amt].
    assign w_lost = x & ~(8'hFF >> amt);
    assign w_last = 8'h01 << (4'd8 - {1'b0, amt});

    assign w_zf = (y == 8'h00);
    assign w_nf = y[7];
    assign w_cf = |(x & w_last);
    assign w_vf = |w_lost;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    assign {r, zf, nf, cf, vf} = r_mem[r_rptr];
    assign count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {y, w_zf, w_nf, w_cf, w_vf};
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_result_stage.sv
// Bench for shift_result_stage: directed cases plus random traffic
// checked against a queue model of the FIFO.
module tb_shift_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [2:0] amt;
    logic [7:0] y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] r;
    logic       zf;
    logic       nf;
    logic       cf;
    logic       vf;
    logic [1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] q[$];

    shift_result_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .amt       (amt),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .zf        (zf),
        .nf        (nf),
        .cf        (cf),
        .vf        (vf),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shift as a 16-bit product: everything above bit 7 fell off the top,
    // and bit 8 is the last bit to leave.
    function automatic logic [11:0] ref_entry(input logic [7:0] xv,
                                              input logic [2:0] av);
        logic [15:0] p;
        logic [7:0]  res;
        p   = {8'h00, xv} << av;
        res = p[7:0];
        return {res, res == 8'h00, res[7], p[8], p[15:8] != 8'h00};
    endfunction

    task automatic drive(input logic v, input logic [7:0] xv,
                         input logic [2:0] av, input logic ordy);
        in_valid  = v;
        x         = xv;
        amt       = av;
        y         = xv << av;
        out_ready = ordy;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".cnt"}, 16'(count), 16'(q.size()));
        check({tag, ".ovld"}, 16'(out_valid), 16'(q.size() != 0));
        check({tag, ".irdy"}, 16'(in_ready), 16'(q.size() < 2));
        if (q.size() != 0)
            check({tag, ".head"}, {4'h0, r, zf, nf, cf, vf}, {4'h0, q[0]});
    endtask

    // Advance one edge, update the model from the driven inputs, check.
    task automatic step(input string tag);
        int  sz;
        bit  psh;
        bit  pp;
        @(posedge clk);
        sz  = q.size();
        psh = in_valid && (sz < 2);
        pp  = out_ready && (sz > 0);
        if (pp) void'(q.pop_front());
        if (psh) q.push_back(ref_entry(x, amt));
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        #2;
        check("rst.cnt", 16'(count), 16'd0);
        check("rst.ovld", 16'(out_valid), 16'd0);
        check("rst.irdy", 16'(in_ready), 16'd1);
        check("rst.rflags", {4'h0, r, zf, nf, cf, vf}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // basic flag cases, each pushed into an empty FIFO
        drive(1'b1, 8'hB5, 3'd3, 1'b1);
        step("t32");
        check("t32.r", 16'(r), 16'h00A8);
        check("t32.fl", 16'({zf, nf, cf, vf}), 16'b0111);
        drive(1'b1, 8'h80, 3'd1, 1'b1);
        step("t33");
        check("t33.r", 16'(r), 16'h0000);
        check("t33.fl", 16'({zf, nf, cf, vf}), 16'b1011);
        drive(1'b1, 8'h01, 3'd0, 1'b1);
        step("t34");
        check("t34.r", 16'(r), 16'h0001);
        check("t34.fl", 16'({zf, nf, cf, vf}), 16'b0000);
        drive(1'b0, 8'h00, 3'd0, 1'b1);
        step("drain0");

        // backpressure and overflow rejection
        drive(1'b1, 8'h11, 3'd0, 1'b0);
        step("bp1");
        drive(1'b1, 8'h22, 3'd0, 1'b0);
        step("bp2");
        check("bp.full", 16'({count, in_ready}), 16'b100);
        drive(1'b1, 8'h33, 3'd0, 1'b0);
        step("bp3");
        check("bp3.r", 16'(r), 16'h0011);
        drive(1'b1, 8'h33, 3'd0, 1'b1);
        step("bp4");
        check("bp4.r", 16'(r), 16'h0022);
        check("bp4.cnt", 16'(count), 16'd1);
        drive(1'b0, 8'h33, 3'd0, 1'b1);
        step("bp5");
        check("bp5.cnt", 16'(count), 16'd0);

        // pop at empty has no effect
        drive(1'b0, 8'h00, 3'd0, 1'b1);
        step("empty_pop");

        // simultaneous push and pop at count 1
        drive(1'b1, 8'h44, 3'd0, 1'b0);
        step("pp1");
        check("pp1.r", 16'(r), 16'h0044);
        drive(1'b1, 8'h55, 3'd0, 1'b1);
        step("pp2");
        check("pp2.cnt", 16'(count), 16'd1);
        check("pp2.r", 16'(r), 16'h0055);
        drive(1'b0, 8'h00, 3'd0, 1'b1);
        step("drain1");

        // random traffic; upstream holds its offer while stalled
        for (int i = 0; i < 2000; i++) begin
            if (!(in_valid && q.size() == 2))
                drive($urandom_range(3, 0) != 0, 8'($urandom),
                      3'($urandom), 1'b0);
            out_ready = ($urandom_range(2, 0) != 0);
            step("rnd");
        end

        // reset mid-operation with a full FIFO
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        step("pre_rst");
        drive(1'b1, 8'hA1, 3'd1, 1'b0);
        step("fill1");
        drive(1'b1, 8'hC3, 3'd2, 1'b0);
        step("fill2");
        drive(1'b1, 8'h00, 3'd0, 1'b0);
        if (count != 2'd2) step("fill3");
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        check("mrst.pre", 16'(count), 16'd2);
        #1 rst_n = 1'b0;
        #1;
        check("mrst.cnt", 16'(count), 16'd0);
        check("mrst.ovld", 16'(out_valid), 16'd0);
        check("mrst.r", 16'(r), 16'd0);
        check("mrst.irdy", 16'(in_ready), 16'd1);
        q.delete();
        #1 rst_n = 1'b1;
        drive(1'b1, 8'h66, 3'd0, 1'b0);
        step("post_rst");
        check("post_rst.r", 16'(r), 16'h0066);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_result_stage.md
SHIFT_RESULT_STAGE -- requirements
Module: shift_result_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  upstream has a shift result to deliver.
REQ-004 in_ready  output  1  stage can accept an entry this cycle.
REQ-005 x  input  8  original operand presented to the 8-bit left shifter.
REQ-006 amt  input  3  shift amount presented to the shifter (amt[0]=s0, amt[1]=s1, amt[2]=s2).
REQ-007 y  input  8  shifter output (x << amt, zero-filled).
REQ-008 out_valid  output  1  output entry available.
REQ-009 out_ready  input  1  downstream accepts the output entry.
REQ-010 r  output  8  registered shift result.
REQ-011 zf  output  1  zero flag: r == 0.
REQ-012 nf  output  1  negative flag: r[7].
REQ-013 cf  output  1  carry flag: last bit shifted out.
REQ-014 vf  output  1  loss flag: any 1 bit shifted out.
REQ-015 count  output  2  current buffer occupancy, 0..2.

Function
REQ-016 The stage SHALL be a 2-entry FIFO holding {r, zf, nf, cf, vf} per entry.
REQ-017 Push SHALL occur on a clock edge where in_valid && in_ready; pop SHALL occur on a clock edge where out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < 2), decoded from registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0); r and the flags SHALL show the head entry.
REQ-020 Latency SHALL be one cycle: an entry pushed into an empty FIFO appears on the outputs the cycle after the push edge; there is no same-cycle bypass.
REQ-021 Flags SHALL be computed at push time from x, amt and y:
  - zf = (y == 0).
  - nf = y[7].
  - cf = 0 if amt == 0, else x[8-amt].
  - vf = 0 if amt == 0, else OR of x[7:8-amt].
REQ-022 Simultaneous push and pop at count 1 SHALL keep count at 1; the head SHALL become the new entry and order SHALL be preserved.
REQ-023 At count 2, in_ready is 0; any in_valid SHALL be ignored and nothing written, even if a pop occurs that cycle.
REQ-024 At count 0, out_valid is 0; out_ready SHALL have no effect.
REQ-025 The FIFO SHALL be strict first-in first-out; entries SHALL be neither dropped nor duplicated.
REQ-026 Read and write pointers SHALL be 1 bit and wrap from 1 to 0.
REQ-027 Upstream SHALL hold x, amt and y stable while in_valid && !in_ready; the stage does not check this.
REQ-028 The y input SHALL be taken as given; the stage SHALL NOT recompute the shift.

Reset
REQ-029 On rst_n low, asynchronously, the following SHALL be cleared: count=0, pointers=0, out_valid=0, r=0, zf=0, nf=0, cf=0, vf=0, in_ready=1.
REQ-030 Reset mid-operation SHALL discard all buffered entries; the first push after rst_n rises SHALL be the first output.
REQ-031 Storage contents other than the head outputs need no reset.

Verification
REQ-032 Push x=8'hB5, amt=3, y=8'hA8, out_ready=1, then expect next cycle: out_valid=1, r=8'hA8, zf=0, nf=1, cf=1, vf=1.
REQ-033 Push x=8'h80, amt=1, y=8'h00, then expect: r=8'h00, zf=1, nf=0, cf=1, vf=1.
REQ-034 Push x=8'h01, amt=0, y=8'h01, then expect: r=8'h01, zf=0, nf=0, cf=0, vf=0.
REQ-035 Backpressure case: hold out_ready=0 and push 0x11 then 0x22, giving count=2 and in_ready=0; offer 0x33, which is ignored; raise out_ready, then expect 0x11, then 0x22, and never 0x33.
REQ-036 Simultaneous push/pop: at count 1 (head 0x44), push 0x55 with out_ready=1 on the same edge, then expect count=1 and r=0x55.
REQ-037 Reset mid-operation: with count=2, pulse rst_n low between edges, then expect immediately count=0, out_valid=0, r=0 and in_ready=1.
